nios2_debug_ocimem: RTL and testbench

- Downstream consumer of the debug-slave wrapper's sysclk-domain outputs: `jdo` and the `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses.
- Owns the on-chip debug RAM, the JTAG-visible monitor address register (`MonAReg`), the monitor data register (`MonDReg`) and the monitor status flags.
- Produces `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the wrapper.
- Exposes a CPU-side Avalon-MM slave so monitor code can share the RAM and status flags.

---
 rtl/nios2_debug_pkg.sv | 41 ++++
 rtl/nios2_debug_ocimem_ram.sv | 70 +++++++
 rtl/nios2_debug_ocimem.sv | 250 +++++++++++++++++++++++++
 tb/tb_nios2_debug_ocimem.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// ---------------------------------------------------------------------------
// nios2_debug_pkg
// Shared definitions for the on-chip debug memory block:
//   - JTAG-side FSM state encoding
//   - bit positions of the fields carried in the 38-bit jdo word
//   - bit positions of the flags in the CPU-visible status register
//   - RAM word width (32, or 33 with the parity bit when
//     NIOS2_DEBUG_OCIMEM_PARITY_EN is defined)
//   - even-parity helper used by the RAM and its consumers
// ---------------------------------------------------------------------------
package nios2_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_WR_ISSUE = 2'd3
  } ocimem_state_e;

  // jdo field positions
  localparam int JDO_RDREQ_BIT = 34;
  localparam int JDO_CLR_BIT   = 35;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_DATA_LSB  = 3;

  // status register flag positions
  localparam int STAT_READY_BIT = 0;
  localparam int STAT_ERROR_BIT = 1;

`ifdef NIOS2_DEBUG_OCIMEM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// ---------------------------------------------------------------------------
// nios2_debug_ocimem_ram
// Single-port synchronous debug RAM, 2**ADDR_W words, 1-cycle read latency.
// Contents are never reset.
//   clk    in   clock
//   en     in   port enable (read when we=0, write when we=1)
//   we     in   write enable
//   addr   in   word address
//   wdata  in   32-bit write data
//   be     in   byte enables for writes
//   q      out  registered read word (RAM_W bits; bit 32 is the stored
//               parity when NIOS2_DEBUG_OCIMEM_PARITY_EN is defined)
// ---------------------------------------------------------------------------
module nios2_debug_ocimem_ram
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [RAM_W-1:0]  q
);

  logic [RAM_W-1:0] mem [2**ADDR_W];

`ifdef NIOS2_DEBUG_OCIMEM_PARITY_EN
  // A partial write must still store parity of the whole resulting word,
  // so the untouched lanes come from the current array contents.
  logic [31:0] merged;

  // Merge enabled write lanes over the stored word.
  always_comb begin
    merged = mem[addr][31:0];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        merged[8*b +: 8] = mem[addr][8*b +: 8];
      end
    end
  end

  // Word write with parity, or registered read.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= {even_parity(merged), merged};
    end else if (en) begin
      q <= mem[addr];
    end
  end
`else
  // Byte-lane write, or registered read.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end else if (en) begin
      q <= mem[addr];
    end
  end
`endif

endmodule

// File: rtl/nios2_debug_ocimem.sv
// ---------------------------------------------------------------------------
// nios2_debug_ocimem
// On-chip debug memory: owns the debug RAM, the JTAG monitor address and
// data registers and the monitor status flags. The JTAG side is driven by
// one-cycle pulses from the debug-slave wrapper; the CPU reaches the same
// RAM and flags through an Avalon-MM slave. JTAG always wins the RAM port.
// Optional build macro: NIOS2_DEBUG_OCIMEM_PARITY_EN (33-bit RAM with even
// parity; read mismatches set monitor_error).
//   clk, reset_n                 clock, synchronous active-low reset
//   jdo                          JTAG data word
//   take_action_ocimem_a         address load / flag clear / read request
//   take_no_action_ocimem_a      streaming read (address pre-increment)
//   take_action_ocimem_b         JTAG write of jdo data at MonAReg
//   avs_*                        CPU slave; address MSB selects status reg
//   MonDReg                      monitor data register
//   monitor_ready, monitor_error status flags
//   jtag_busy                    JTAG RAM access in progress
// RAM_INIT_ZERO only documents whether the memory image zero-fills the RAM;
// the logic never depends on initial RAM contents.
// ---------------------------------------------------------------------------
module nios2_debug_ocimem
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int RAM_INIT_ZERO = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [37:0]     jdo,
  input  logic            take_action_ocimem_a,
  input  logic            take_no_action_ocimem_a,
  input  logic            take_action_ocimem_b,
  input  logic [ADDR_W:0] avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  input  logic [3:0]      avs_byteenable,
  output logic [31:0]     avs_readdata,
  output logic            avs_waitrequest,
  output logic [31:0]     MonDReg,
  output logic            monitor_ready,
  output logic            monitor_error,
  output logic            jtag_busy
);

  localparam int unused_ram_init_zero = RAM_INIT_ZERO;

  ocimem_state_e     state;
  ocimem_state_e     state_next;
  logic [ADDR_W-1:0] mon_a_reg;

  logic              sel_a;
  logic              sel_n;
  logic              sel_b;
  logic              fsm_idle;
  logic              jtag_pulse;

  logic              cpu_req;
  logic              cpu_wr;
  logic              cpu_status;
  logic              cpu_fresh;
  logic              status_grant;
  logic              cpu_ram_grant;
  logic              cpu_rd_pend;
  logic              cpu_done;
  logic              rst_hold;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic [RAM_W-1:0]  ram_q;

  logic              unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  // Pulse priority: ocimem_b over ocimem_a over no_action_a.
  assign sel_b      = take_action_ocimem_b;
  assign sel_a      = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_n      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign fsm_idle   = (state == ST_IDLE);
  assign jtag_pulse = fsm_idle & (sel_a | sel_n | sel_b);

  // A fresh CPU request is one not already being completed.
  assign cpu_req       = avs_read | avs_write;
  assign cpu_wr        = avs_write;
  assign cpu_status    = avs_address[ADDR_W];
  assign cpu_fresh     = cpu_req & ~cpu_done & ~cpu_rd_pend & ~rst_hold;
  assign status_grant  = cpu_fresh & cpu_status;
  assign cpu_ram_grant = cpu_fresh & ~cpu_status & fsm_idle & ~jtag_pulse;

  // Stall until the access has produced its result; the stall must rise in
  // the request's first cycle, so it cannot wait for a clock edge.
  assign avs_waitrequest = rst_hold | (cpu_req & ~cpu_done);

`ifdef NIOS2_DEBUG_OCIMEM_PARITY_EN
  logic par_err;
  assign par_err = (even_parity(ram_q[31:0]) != ram_q[32]);
`endif

  // JTAG FSM next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (sel_b) begin
          state_next = ST_WR_ISSUE;
        end else if (sel_a) begin
          if (jdo[JDO_RDREQ_BIT]) begin
            state_next = ST_RD_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (sel_n) begin
          state_next = ST_RD_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_next = ST_RD_WAIT;
      ST_RD_WAIT:  state_next = ST_IDLE;
      ST_WR_ISSUE: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // RAM port arbitration: JTAG issue states own the port, otherwise a
  // granted CPU RAM access does.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = mon_a_reg;
    ram_wdata = MonDReg;
    ram_be    = 4'hF;
    case (state)
      ST_RD_ISSUE: begin
        ram_en = 1'b1;
      end
      ST_WR_ISSUE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: begin
        if (cpu_ram_grant) begin
          ram_en    = 1'b1;
          ram_we    = cpu_wr;
          ram_addr  = avs_address[ADDR_W-1:0];
          ram_wdata = avs_writedata;
          ram_be    = avs_byteenable;
        end else begin
          ram_en = 1'b0;
        end
      end
    endcase
  end

  // JTAG FSM state, monitor address and monitor data registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      jtag_busy <= 1'b0;
      mon_a_reg <= '0;
      MonDReg   <= 32'h0000_0000;
    end else begin
      state     <= state_next;
      jtag_busy <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sel_b) begin
            MonDReg <= jdo[JDO_DATA_LSB +: 32];
          end else if (sel_a) begin
            mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
          end else if (sel_n) begin
            mon_a_reg <= mon_a_reg + ADDR_W'(1);
          end
        end
        ST_RD_WAIT:  MonDReg   <= ram_q[31:0];
        ST_WR_ISSUE: mon_a_reg <= mon_a_reg + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // CPU access sequencing: status in one step, RAM write in one step,
  // RAM read through a pending step that captures the RAM output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_hold     <= 1'b1;
      cpu_done     <= 1'b0;
      cpu_rd_pend  <= 1'b0;
      avs_readdata <= 32'h0000_0000;
    end else begin
      rst_hold <= 1'b0;
      if (cpu_done) begin
        cpu_done <= 1'b0;
      end else if (cpu_rd_pend) begin
        cpu_rd_pend  <= 1'b0;
        cpu_done     <= 1'b1;
        avs_readdata <= ram_q[31:0];
      end else if (status_grant) begin
        cpu_done <= 1'b1;
        if (!cpu_wr) begin
          avs_readdata <= {30'd0, monitor_error, monitor_ready};
        end
      end else if (cpu_ram_grant) begin
        if (cpu_wr) begin
          cpu_done <= 1'b1;
        end else begin
          cpu_rd_pend <= 1'b1;
        end
      end
    end
  end

  // Monitor flags; the JTAG clear is last so it wins a same-cycle CPU write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (status_grant && cpu_wr && avs_byteenable[0]) begin
        monitor_ready <= avs_writedata[STAT_READY_BIT];
        monitor_error <= avs_writedata[STAT_ERROR_BIT];
      end
`ifdef NIOS2_DEBUG_OCIMEM_PARITY_EN
      if (((state == ST_RD_WAIT) || cpu_rd_pend) && par_err) begin
        monitor_error <= 1'b1;
      end
`endif
      if (fsm_idle && sel_a && jdo[JDO_CLR_BIT]) begin
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
      end
    end
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_ocimem
// Directed bench for nios2_debug_ocimem: a table of JTAG/CPU operations with
// hand-computed expectations, plus hand-written sequences for reset, read
// latency, CPU/JTAG contention, the status clear race and reset mid-read.
// ---------------------------------------------------------------------------
module tb_nios2_debug_ocimem;

  localparam int OP_LOAD   = 0;
  localparam int OP_STREAM = 1;
  localparam int OP_JWR    = 2;
  localparam int OP_CRD    = 3;
  localparam int OP_CWR    = 4;
  localparam int NV        = 22;
  localparam int LIMIT     = 40;

  typedef struct {
    int          op;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        rdreq;
    logic        chk_d;
    logic [31:0] exp_d;
    logic [7:0]  exp_a;
    int          exp_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = 38'd0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [8:0]  avs_address = 9'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [3:0]  avs_byteenable = 4'd0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        jtag_busy;

  int errors = 0;
  int checks = 0;
  vec_t vecs[NV];

  nios2_debug_ocimem #(.ADDR_W(8), .RAM_INIT_ZERO(1)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .jtag_busy               (jtag_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [8:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic rdreq, input logic chk_d,
                              input logic [31:0] exp_d, input logic [7:0] exp_a, input int exp_w);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.be = be; v.rdreq = rdreq;
    v.chk_d = chk_d; v.exp_d = exp_d; v.exp_a = exp_a; v.exp_w = exp_w;
    return v;
  endfunction

  function automatic logic [37:0] make_a(input logic [7:0] addr, input logic rdreq, input logic clr);
    logic [37:0] j;
    j = 38'd0;
    j[24:17] = addr;
    j[34] = rdreq;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] make_b(input logic [31:0] data);
    logic [37:0] j;
    j = 38'd0;
    j[34:3] = data;
    return j;
  endfunction

  // Called just after a posedge; one-cycle pulse then a 5-cycle gap.
  task automatic jtag_pulse(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(posedge clk); #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns after the completing edge.
  task automatic cpu_xfer(input logic rd, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output int waits);
    avs_address    = addr;
    avs_read       = rd;
    avs_write      = ~rd;
    avs_writedata  = wd;
    avs_byteenable = be;
    waits = 0;
    @(negedge clk);
    while (avs_waitrequest && waits < LIMIT) begin
      waits++;
      @(negedge clk);
    end
    rdata = avs_readdata;
    chk("xfer_bound", 32'(waits < LIMIT), 32'd1);
    @(posedge clk); #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int w;

    vecs[0]  = mk(OP_LOAD,   9'h010, 32'h0,        4'h0,    1'b0, 1'b0, 32'h0,        8'h10, 0);
    vecs[1]  = mk(OP_JWR,    9'h000, 32'hDEADBEEF, 4'h0,    1'b0, 1'b1, 32'hDEADBEEF, 8'h11, 0);
    vecs[2]  = mk(OP_CRD,    9'h010, 32'h0,        4'hF,    1'b0, 1'b1, 32'hDEADBEEF, 8'h00, 2);
    vecs[3]  = mk(OP_CWR,    9'h0FF, 32'h00000001, 4'hF,    1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[4]  = mk(OP_CWR,    9'h000, 32'h00000002, 4'hF,    1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[5]  = mk(OP_CWR,    9'h001, 32'h11223344, 4'hF,    1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[6]  = mk(OP_CWR,    9'h001, 32'hFFFFFFFF, 4'b1010, 1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[7]  = mk(OP_LOAD,   9'h0FF, 32'h0,        4'h0,    1'b1, 1'b1, 32'h00000001, 8'hFF, 0);
    vecs[8]  = mk(OP_STREAM, 9'h000, 32'h0,        4'h0,    1'b0, 1'b1, 32'h00000002, 8'h00, 0);
    vecs[9]  = mk(OP_STREAM, 9'h000, 32'h0,        4'h0,    1'b0, 1'b1, 32'hFF22FF44, 8'h01, 0);
    vecs[10] = mk(OP_JWR,    9'h000, 32'h0BADF00D, 4'h0,    1'b0, 1'b1, 32'h0BADF00D, 8'h02, 0);
    vecs[11] = mk(OP_CRD,    9'h001, 32'h0,        4'hF,    1'b0, 1'b1, 32'h0BADF00D, 8'h00, 2);
    vecs[12] = mk(OP_CWR,    9'h100, 32'h00000003, 4'h1,    1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[13] = mk(OP_CRD,    9'h100, 32'h0,        4'hF,    1'b0, 1'b1, 32'h00000003, 8'h00, 1);
    vecs[14] = mk(OP_CRD,    9'h1FF, 32'h0,        4'hF,    1'b0, 1'b1, 32'h00000003, 8'h00, 1);
    vecs[15] = mk(OP_CWR,    9'h100, 32'h00000000, 4'b1110, 1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[16] = mk(OP_CRD,    9'h100, 32'h0,        4'hF,    1'b0, 1'b1, 32'h00000003, 8'h00, 1);
    vecs[17] = mk(OP_CWR,    9'h180, 32'h00000001, 4'h1,    1'b0, 1'b0, 32'h0,        8'h00, 1);
    vecs[18] = mk(OP_CRD,    9'h100, 32'h0,        4'hF,    1'b0, 1'b1, 32'h00000001, 8'h00, 1);
    vecs[19] = mk(OP_LOAD,   9'h0FF, 32'h0,        4'h0,    1'b0, 1'b0, 32'h0,        8'hFF, 0);
    vecs[20] = mk(OP_JWR,    9'h000, 32'h55AA55AA, 4'h0,    1'b0, 1'b1, 32'h55AA55AA, 8'h00, 0);
    vecs[21] = mk(OP_CRD,    9'h0FF, 32'h0,        4'hF,    1'b0, 1'b1, 32'h55AA55AA, 8'h00, 2);

    // Reset for two edges, then release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_monareg", 32'(dut.mon_a_reg), 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'h1);
    chk("rst_busy", 32'(jtag_busy), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_exit_waitreq", 32'(avs_waitrequest), 32'h0);

    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_LOAD:   jtag_pulse(0, make_a(vecs[i].addr[7:0], vecs[i].rdreq, 1'b0));
        OP_STREAM: jtag_pulse(1, 38'd0);
        OP_JWR:    jtag_pulse(2, make_b(vecs[i].data));
        OP_CRD:    cpu_xfer(1'b1, vecs[i].addr, 32'h0, 4'hF, rd, w);
        default:   cpu_xfer(1'b0, vecs[i].addr, vecs[i].data, vecs[i].be, rd, w);
      endcase
      if (vecs[i].op <= OP_JWR) begin
        chk($sformatf("v%0d_monareg", i), 32'(dut.mon_a_reg), 32'(vecs[i].exp_a));
        chk($sformatf("v%0d_busy", i), 32'(jtag_busy), 32'h0);
      end else begin
        chk($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].exp_w));
      end
      if (vecs[i].chk_d && vecs[i].op <= OP_JWR) begin
        chk($sformatf("v%0d_mondreg", i), MonDReg, vecs[i].exp_d);
      end
      if (vecs[i].op == OP_CRD) begin
        chk($sformatf("v%0d_readdata", i), rd, vecs[i].exp_d);
      end
    end

    // Read latency: MonDReg changes on the third edge after the pulse.
    cpu_xfer(1'b0, 9'h0FF, 32'h00000001, 4'hF, rd, w);
    jdo = make_a(8'hFF, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    chk("lat_busy_e1", 32'(jtag_busy), 32'h1);
    @(posedge clk); #1;
    chk("lat_old_e2", MonDReg, 32'h55AA55AA);
    @(posedge clk); #1;
    chk("lat_new_e3", MonDReg, 32'h00000001);
    repeat (3) @(posedge clk);
    #1;

    // Contention: CPU write to 0x005 in the same cycle as a JTAG write.
    jtag_pulse(0, make_a(8'h05, 1'b0, 1'b0));
    jdo = make_b(32'hCAFEBABE);
    take_action_ocimem_b = 1'b1;
    avs_address = 9'h005; avs_write = 1'b1; avs_writedata = 32'h12345678; avs_byteenable = 4'b0011;
    w = 0;
    @(negedge clk);
    if (avs_waitrequest) w++;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    @(negedge clk);
    chk("cont_busy_hold", 32'({jtag_busy, avs_waitrequest}), 32'h3);
    while (avs_waitrequest && w < LIMIT) begin
      w++;
      @(negedge clk);
    end
    chk("cont_waits", 32'(w), 32'd3);
    chk("cont_busy_done", 32'(jtag_busy), 32'h0);
    @(posedge clk); #1;
    avs_write = 1'b0;
    chk("cont_monareg", 32'(dut.mon_a_reg), 32'h06);
    cpu_xfer(1'b1, 9'h005, 32'h0, 4'hF, rd, w);
    chk("cont_merge", rd, 32'hCAFE5678);

    // Status handshake and JTAG clear racing a CPU status write.
    cpu_xfer(1'b0, 9'h100, 32'h00000003, 4'h1, rd, w);
    chk("stat_flags_set", 32'({monitor_error, monitor_ready}), 32'h3);
    jdo = make_a(8'h40, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    avs_address = 9'h100; avs_write = 1'b1; avs_writedata = 32'h00000003; avs_byteenable = 4'h1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    @(negedge clk);
    chk("race_waitreq", 32'(avs_waitrequest), 32'h0);
    @(posedge clk); #1;
    avs_write = 1'b0;
    chk("race_flags", 32'({monitor_error, monitor_ready}), 32'h0);
    cpu_xfer(1'b1, 9'h100, 32'h0, 4'hF, rd, w);
    chk("race_status_rd", rd, 32'h0);
    repeat (4) @(posedge clk);
    #1;

    // Reset during a pending JTAG read drops it; RAM keeps its contents.
    jdo = make_a(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(jtag_busy), 32'h0);
    chk("midrst_mondreg", MonDReg, 32'h0);
    chk("midrst_waitreq", 32'(avs_waitrequest), 32'h1);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", MonDReg, 32'h0);
    cpu_xfer(1'b1, 9'h010, 32'h0, 4'hF, rd, w);
    chk("midrst_ram_kept", rd, 32'hDEADBEEF);

`ifdef NIOS2_DEBUG_OCIMEM_PARITY_EN
    cpu_xfer(1'b0, 9'h020, 32'h12345678, 4'hF, rd, w);
    dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 33'h1;
    jtag_pulse(0, make_a(8'h20, 1'b1, 1'b0));
    chk("par_error", 32'(monitor_error), 32'h1);
    chk("par_raw", MonDReg, 32'h12345679);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
